sobel_raster_addr: RTL

Raster-scan address generator for the Sobel HLS datapath. It walks a frame row by row and drives the row-index × row-pitch operands of the 6×8→13-bit unsigned multiplier. It takes the product back, adds the column index and emits a registered pixel-address stream with a valid/ready handshake to the frame-buffer read stage. One start pulse produces one complete frame of addresses.

---
 rtl/sobel_raster_addr_if.sv | 24 ++
 rtl/sobel_raster_addr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sobel_raster_addr_if.sv
// Pixel-address stream from the raster generator to the frame-buffer read stage.
// Valid/ready handshake; addr_last marks the final address of a frame.
interface sobel_raster_addr_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] addr_data;
  logic              addr_valid;
  logic              addr_ready;
  logic              addr_last;

  modport master (
    output addr_data,
    output addr_valid,
    output addr_last,
    input  addr_ready
  );

  modport slave (
    input  addr_data,
    input  addr_valid,
    input  addr_last,
    output addr_ready
  );
endinterface

// File: rtl/sobel_raster_addr.sv
// Raster-scan pixel-address generator feeding the Sobel row*pitch multiplier.
// Define SOBEL_ADDR_BORDER_EN to emit only the 3x3-kernel interior pixels.
module sobel_raster_addr #(
  parameter int ROW_W  = 6,
  parameter int COL_W  = 8,
  parameter int ADDR_W = 13
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 start,
  input  logic [ROW_W-1:0]     img_rows,
  input  logic [COL_W-1:0]     img_cols,
  output logic [ROW_W-1:0]     mul_din0,
  output logic [COL_W-1:0]     mul_din1,
  input  logic [ADDR_W-1:0]    mul_dout,
  sobel_raster_addr_if.master  addr_if,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

`ifdef SOBEL_ADDR_BORDER_EN
  localparam int EDGE = 1;
`else
  localparam int EDGE = 0;
`endif
  localparam int PW   = ROW_W + COL_W + 1;
  localparam int AMAX = (1 << ADDR_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [COL_W-1:0]   cols_q, cols_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               exh_q, exh_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ROW_W-1:0]   last_row;
  logic [COL_W-1:0]   last_col;
  logic               is_last;
  logic               hs;
  logic               load;
  logic               non_empty;
  logic [ADDR_W:0]    sum;
  logic [PW-1:0]      prod;
  logic               wide;

  assign last_row  = rows_q - ROW_W'(EDGE + 1);
  assign last_col  = cols_q - COL_W'(EDGE + 1);
  assign is_last   = (row_q == last_row) && (col_q == last_col);
  assign hs        = valid_q && addr_if.addr_ready;
  assign load      = (state_q == S_RUN) && !exh_q
                   && (!valid_q || addr_if.addr_ready);
  assign non_empty = (img_rows >= ROW_W'(2 * EDGE + 1))
                   && (img_cols >= COL_W'(2 * EDGE + 1));
  assign sum       = (ADDR_W + 1)'(mul_dout) + (ADDR_W + 1)'(col_q);
  // The truncated product can hide rows whose base already exceeds the range.
  assign prod      = PW'(row_q) * PW'(cols_q);
  assign wide      = prod > PW'(AMAX);

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    exh_d   = exh_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = img_rows;
          cols_d  = img_cols;
          row_d   = ROW_W'(EDGE);
          col_d   = COL_W'(EDGE);
          ovf_d   = 1'b0;
          exh_d   = 1'b0;
          state_d = non_empty ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        if (load) begin
          data_d  = sum[ADDR_W-1:0];
          ovf_d   = ovf_q | sum[ADDR_W] | wide;
          last_d  = is_last;
          valid_d = 1'b1;
          exh_d   = is_last;
          if (col_q == last_col) begin
            col_d = COL_W'(EDGE);
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        if (hs && last_q && !load) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      exh_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      exh_q   <= exh_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mul_din0           = row_q;
  assign mul_din1           = cols_q;
  assign addr_if.addr_data  = data_q;
  assign addr_if.addr_valid = valid_q;
  assign addr_if.addr_last  = last_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign ovf                = ovf_q;

endmodule
